// File: rtl/cache_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_port_arbiter
// Purpose  : Shares one direct-mapped write-through cache port between NREQ
//            requesters. Round-robin grant, one outstanding cache command at a
//            time; the command is held stable until cache_ack, then the read
//            data (or write completion) is returned to the granted requester.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            req_valid/we/addr/wdata (in, per requester, flattened)
//            req_ready  (out)    - one-hot accept pulse, combinational, IDLE only
//            rsp_valid  (out)    - one-hot 1-cycle completion pulse, registered
//            rsp_rdata  (out)    - read data with rsp_valid, 0 for writes
//            rsp_err    (out)    - timeout flag (only with CACHE_ARB_TIMEOUT_EN)
//            cache_rd/wr/addr/wdata (out) - command to the cache
//            cache_ack/rdata (in)         - completion pulse and read data
//            busy       (out)    - high while a command is outstanding
// Options  : CACHE_ARB_TIMEOUT_EN - watchdog drops a command after TMO_CYCLES
//            BUSY cycles without cache_ack and answers with rsp_err=1.
// Revision : 1.0 - initial release
// ============================================================================
module cache_port_arbiter #(
    parameter int NREQ       = 2,
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int TMO_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DW-1:0]        rsp_rdata,
`ifdef CACHE_ARB_TIMEOUT_EN
    output logic                 rsp_err,
`endif
    output logic                 cache_rd,
    output logic                 cache_wr,
    output logic [AW-1:0]        cache_addr,
    output logic [DW-1:0]        cache_wdata,
    input  logic                 cache_ack,
    input  logic [DW-1:0]        cache_rdata,
    output logic                 busy
);

    localparam int PW = (NREQ > 2) ? 2 : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [PW-1:0]   r_rr_ptr;
    logic [PW-1:0]   r_owner;
    logic [PW-1:0]   w_winner;
    logic [PW-1:0]   w_owner_next;
    logic            w_found;
    logic            w_grant;
    logic            w_done;
    logic            w_timeout;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [NREQ-1:0] r_rsp_valid;
    logic [DW-1:0]   r_rsp_rdata;

    // Round-robin search: first pending requester starting at r_rr_ptr.
    always_comb begin
        int            v_sum;
        logic [PW-1:0] v_idx;
        w_found  = 1'b0;
        w_winner = '0;
        v_sum    = 0;
        v_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            v_sum = int'(r_rr_ptr) + k;
            if (v_sum >= NREQ) begin
                v_sum = v_sum - NREQ;
            end
            v_idx = v_sum[PW-1:0];
            if (!w_found && req_valid[v_idx]) begin
                w_found  = 1'b1;
                w_winner = v_idx;
            end
        end
    end

    // Pointer moves past the owner only on completion, so a waiting
    // requester is always next in line.
    always_comb begin
        if (int'(r_owner) == NREQ - 1) begin
            w_owner_next = '0;
        end else begin
            w_owner_next = r_owner + 1'b1;
        end
    end

`ifdef CACHE_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TMO_CYCLES + 1);
    logic [CW-1:0] r_tmo_cnt;
    logic          r_rsp_err;

    // Counter holds the number of BUSY cycles already completed, so the
    // drop happens in the TMO_CYCLES-th BUSY cycle.
    assign w_timeout = (r_state == ST_BUSY) && !cache_ack &&
                       (r_tmo_cnt == CW'(TMO_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo_cnt <= '0;
        end else if (w_grant) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_BUSY) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_err <= 1'b0;
        end else begin
            r_rsp_err <= w_done && w_timeout;
        end
    end

    assign rsp_err = r_rsp_err;
`else
    logic w_tmo_unused;
    assign w_timeout    = 1'b0;
    assign w_tmo_unused = (TMO_CYCLES > 0);
`endif

    assign w_grant = (r_state == ST_IDLE) && w_found;
    assign w_done  = (r_state == ST_BUSY) && (cache_ack || w_timeout);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and accept pulse
    always_comb begin
        w_state_next = r_state;
        req_ready    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    req_ready[w_winner] = 1'b1;
                    w_state_next        = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Command latch, round-robin pointer and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            if (w_grant) begin
                r_owner <= w_winner;
                r_we    <= req_we[w_winner];
                r_addr  <= req_addr[int'(w_winner) * AW +: AW];
                r_wdata <= req_wdata[int'(w_winner) * DW +: DW];
            end
            if (w_done) begin
                r_rsp_valid[r_owner] <= 1'b1;
                r_rsp_rdata          <= (r_we || w_timeout) ? '0 : cache_rdata;
                r_rr_ptr             <= w_owner_next;
            end
        end
    end

    assign busy        = (r_state == ST_BUSY);
    assign cache_rd    = busy && !r_we;
    assign cache_wr    = busy && r_we;
    assign cache_addr  = r_addr;
    assign cache_wdata = r_wdata;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;

endmodule
`default_nettype wire
